// File: rtl/dram_request_arbiter.sv
// Round-robin front end merging one write stream and N_RD read streams onto the
// UberDDR3 request port, with an in-order tag FIFO and per-channel response credits.
module dram_request_arbiter #(
  parameter int ADDR_W          = 24,
  parameter int DATA_W          = 128,
  parameter int N_RD            = 2,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CREDITS         = 8
) (
  input  logic                               clk_dram_ctrl,
  input  logic                               rst_dram_ctrl_n,
  input  logic [DATA_W-1:0]                  wr_axis_data,
  input  logic [ADDR_W-1:0]                  wr_axis_addr,
  input  logic                               wr_axis_valid,
  output logic                               wr_axis_ready,
  input  logic [N_RD*ADDR_W-1:0]             rd_addr_axis_data,
  input  logic [N_RD-1:0]                    rd_addr_axis_valid,
  output logic [N_RD-1:0]                    rd_addr_axis_ready,
  output logic [DATA_W-1:0]                  rd_data_axis_data,
  output logic [ADDR_W-1:0]                  rd_data_axis_addr,
  output logic [N_RD-1:0]                    rd_data_axis_valid,
  input  logic [N_RD-1:0]                    rd_credit_return,
  output logic [ADDR_W-1:0]                  memrequest_addr,
  output logic                               memrequest_en,
  output logic [DATA_W-1:0]                  memrequest_write_data,
  output logic                               memrequest_write_enable,
  input  logic [DATA_W-1:0]                  memrequest_resp_data,
  input  logic                               memrequest_complete,
  input  logic                               memrequest_busy,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_count,
  output logic                               err_underflow
);

  localparam int SLOTS = N_RD + 1;
  localparam int PTR_W = $clog2(SLOTS);
  localparam int CH_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int FA_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = FA_W + 1;
  localparam int CR_W  = 8;

  localparam logic [PTR_W:0]   SLOTS_W    = (PTR_W + 1)'(SLOTS);
  localparam logic [PTR_W-1:0] WR_SLOT    = PTR_W'(N_RD);
  localparam logic [CR_W-1:0]  CREDIT_MAX = CR_W'(CREDITS);

  typedef struct packed {
    logic              is_wr;
    logic [CH_W-1:0]   chan;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             err_underflow_reg, err_underflow_next;

  logic [SLOTS-1:0] eligible;
  logic [SLOTS-1:0] elig_rot;
  logic [SLOTS-1:0] grant_oh;
  logic [N_RD-1:0]  credit_nz;
  logic [PTR_W-1:0] grant_offset;
  logic [PTR_W:0]   grant_sum;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic             issue;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_pop;
  logic             resp_rd;
  logic [ADDR_W-1:0] rd_sel_addr;
  tag_t             push_tag;
  tag_t             head_tag;
  tag_t             tag_mem [MAX_OUTSTANDING];

  // ---------------------------------------------------------------- eligibility
  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_elig
      assign eligible[gi] = rd_addr_axis_valid[gi] && credit_nz[gi];
    end
  endgenerate
  assign eligible[N_RD] = wr_axis_valid;

  // Rotate so that bit 0 is the slot at rr_ptr; the lowest set bit is the winner.
  assign elig_rot = (eligible >> rr_ptr_reg) | (eligible << (SLOTS_W - {1'b0, rr_ptr_reg}));

  always_comb begin
    grant_found  = 1'b0;
    grant_offset = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        grant_found  = 1'b1;
        grant_offset = PTR_W'(k);
      end
    end
  end

  assign grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_offset};
  assign grant_idx = (grant_sum >= SLOTS_W) ? PTR_W'(grant_sum - SLOTS_W) : grant_sum[PTR_W-1:0];

  assign outstanding_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full         = outstanding_count[CNT_W-1];
  assign fifo_empty        = (wr_ptr_reg == rd_ptr_reg);

  // Reset gating keeps every handshake output low while rst_dram_ctrl_n is asserted.
  assign issue = rst_dram_ctrl_n && grant_found && !memrequest_busy && !fifo_full;

  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_grant
      assign grant_oh[gi] = issue && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  assign rd_addr_axis_ready = grant_oh[N_RD-1:0];
  assign wr_axis_ready      = grant_oh[N_RD];

  always_comb begin
    rd_sel_addr = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (grant_oh[k]) begin
        rd_sel_addr = rd_sel_addr | rd_addr_axis_data[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---------------------------------------------------------------- request port
  always_comb begin
    memrequest_en           = 1'b0;
    memrequest_write_enable = 1'b0;
    memrequest_addr         = '0;
    memrequest_write_data   = '0;
    if (issue) begin
      memrequest_en = 1'b1;
      if (grant_oh[N_RD]) begin
        memrequest_write_enable = 1'b1;
        memrequest_addr         = wr_axis_addr;
        memrequest_write_data   = wr_axis_data;
      end else begin
        memrequest_addr = rd_sel_addr;
      end
    end
  end

  always_comb begin
    push_tag       = '0;
    push_tag.is_wr = grant_oh[N_RD];
    push_tag.chan  = CH_W'(grant_idx);
    push_tag.addr  = memrequest_addr;
  end

  assign rr_ptr_next = !issue ? rr_ptr_reg
                     : (grant_idx == WR_SLOT) ? '0
                     : grant_idx + PTR_W'(1);

  // ---------------------------------------------------------------- tag FIFO
  always_ff @(posedge clk_dram_ctrl) begin
    if (issue) begin
      tag_mem[wr_ptr_reg[FA_W-1:0]] <= push_tag;
    end
  end

  assign head_tag = tag_mem[rd_ptr_reg[FA_W-1:0]];
  assign do_pop   = rst_dram_ctrl_n && memrequest_complete && !fifo_empty;
  assign resp_rd  = do_pop && !head_tag.is_wr;

  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_resp
      assign rd_data_axis_valid[gi] = resp_rd && (head_tag.chan == CH_W'(gi));
    end
  endgenerate

  assign rd_data_axis_data = resp_rd ? memrequest_resp_data : '0;
  assign rd_data_axis_addr = resp_rd ? head_tag.addr : '0;

  assign err_underflow_next = err_underflow_reg || (memrequest_complete && fifo_empty);
  assign err_underflow      = err_underflow_reg;

  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) begin
      rr_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      err_underflow_reg <= 1'b0;
    end else begin
      rr_ptr_reg        <= rr_ptr_next;
      err_underflow_reg <= err_underflow_next;
      if (issue) begin
        wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- credits
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_credit
      logic [CR_W-1:0] credit_reg, credit_next;
      logic            take, give;

      assign take = grant_oh[gi];
      assign give = rd_credit_return[gi];

      // A return while already full is dropped rather than wrapping.
      always_comb begin
        credit_next = credit_reg;
        if (take && !give) begin
          credit_next = credit_reg - CR_W'(1);
        end else if (give && !take && (credit_reg != CREDIT_MAX)) begin
          credit_next = credit_reg + CR_W'(1);
        end
      end

      always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        if (!rst_dram_ctrl_n) begin
          credit_reg <= CREDIT_MAX;
        end else begin
          credit_reg <= credit_next;
        end
      end

      assign credit_nz[gi] = (credit_reg != '0);
    end
  endgenerate

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter with default parameters (N_RD=2,
// MAX_OUTSTANDING=64, CREDITS=8): a vector table plus hand-written corner sequences.
module tb_dram_request_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 128;
  localparam int N_RD   = 2;

  localparam logic [ADDR_W-1:0] A_CH0 = 24'h000030;
  localparam logic [ADDR_W-1:0] A_CH1 = 24'h000010;
  localparam logic [ADDR_W-1:0] A_WR  = 24'h000020;
  localparam logic [DATA_W-1:0] WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;

  logic                     clk_dram_ctrl = 1'b0;
  logic                     rst_dram_ctrl_n;
  logic [DATA_W-1:0]        wr_axis_data;
  logic [ADDR_W-1:0]        wr_axis_addr;
  logic                     wr_axis_valid;
  logic                     wr_axis_ready;
  logic [N_RD*ADDR_W-1:0]   rd_addr_axis_data;
  logic [N_RD-1:0]          rd_addr_axis_valid;
  logic [N_RD-1:0]          rd_addr_axis_ready;
  logic [DATA_W-1:0]        rd_data_axis_data;
  logic [ADDR_W-1:0]        rd_data_axis_addr;
  logic [N_RD-1:0]          rd_data_axis_valid;
  logic [N_RD-1:0]          rd_credit_return;
  logic [ADDR_W-1:0]        memrequest_addr;
  logic                     memrequest_en;
  logic [DATA_W-1:0]        memrequest_write_data;
  logic                     memrequest_write_enable;
  logic [DATA_W-1:0]        memrequest_resp_data;
  logic                     memrequest_complete;
  logic                     memrequest_busy;
  logic [6:0]               outstanding_count;
  logic                     err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk_dram_ctrl = ~clk_dram_ctrl;

  dram_request_arbiter dut (
    .clk_dram_ctrl           (clk_dram_ctrl),
    .rst_dram_ctrl_n         (rst_dram_ctrl_n),
    .wr_axis_data            (wr_axis_data),
    .wr_axis_addr            (wr_axis_addr),
    .wr_axis_valid           (wr_axis_valid),
    .wr_axis_ready           (wr_axis_ready),
    .rd_addr_axis_data       (rd_addr_axis_data),
    .rd_addr_axis_valid      (rd_addr_axis_valid),
    .rd_addr_axis_ready      (rd_addr_axis_ready),
    .rd_data_axis_data       (rd_data_axis_data),
    .rd_data_axis_addr       (rd_data_axis_addr),
    .rd_data_axis_valid      (rd_data_axis_valid),
    .rd_credit_return        (rd_credit_return),
    .memrequest_addr         (memrequest_addr),
    .memrequest_en           (memrequest_en),
    .memrequest_write_data   (memrequest_write_data),
    .memrequest_write_enable (memrequest_write_enable),
    .memrequest_resp_data    (memrequest_resp_data),
    .memrequest_complete     (memrequest_complete),
    .memrequest_busy         (memrequest_busy),
    .outstanding_count       (outstanding_count),
    .err_underflow           (err_underflow)
  );

  typedef struct {
    logic [1:0]        rd_v;
    logic              wr_v;
    logic              busy;
    logic              cmpl;
    logic [DATA_W-1:0] rdata;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        rd_rdy;
    logic              wr_rdy;
    logic [1:0]        dv;
    logic [ADDR_W-1:0] daddr;
    logic [6:0]        cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dram_ctrl);
    #1;
  endtask

  task automatic idle_inputs();
    rd_addr_axis_valid  = '0;
    wr_axis_valid       = 1'b0;
    memrequest_busy     = 1'b0;
    memrequest_complete = 1'b0;
    rd_credit_return    = '0;
    memrequest_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_dram_ctrl_n = 1'b0;
    tick();
    tick();
    rst_dram_ctrl_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_axis_data      = WDATA;
    wr_axis_addr      = A_WR;
    rd_addr_axis_data = {A_CH1, A_CH0};
    idle_inputs();
    rst_dram_ctrl_n = 1'b0;
    #3;

    // Asynchronous reset: outputs low before any clock edge, even with valids high.
    rd_addr_axis_valid = 2'b11;
    wr_axis_valid      = 1'b1;
    #1;
    chk("rst_en", memrequest_en, 1'b0);
    chk("rst_rd_ready", rd_addr_axis_ready, 2'b00);
    chk("rst_wr_ready", wr_axis_ready, 1'b0);
    chk("rst_count", outstanding_count, 7'd0);
    chk("rst_err", err_underflow, 1'b0);
    do_reset();
    #1;
    chk("post_rst_count", outstanding_count, 7'd0);
    chk("post_rst_en", memrequest_en, 1'b0);

    // Vector table: round robin, response routing, simultaneous issue/complete, busy hold.
    //          rd_v   wr   busy cmpl rdata        en   we   addr   rd_rdy wr_rdy dv     daddr  cnt
    vecs[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 128'h0,   1'b1, 1'b0, A_CH0, 2'b01, 1'b0, 2'b00, 24'h0, 7'd1};
    vecs[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 128'h0,   1'b1, 1'b0, A_CH1, 2'b10, 1'b0, 2'b00, 24'h0, 7'd2};
    vecs[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 128'h0,   1'b1, 1'b1, A_WR,  2'b00, 1'b1, 2'b00, 24'h0, 7'd3};
    vecs[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 128'h0,   1'b1, 1'b0, A_CH0, 2'b01, 1'b0, 2'b00, 24'h0, 7'd4};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 1'b1, 128'hA11, 1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 2'b01, A_CH0, 7'd3};
    vecs[5]  = '{2'b00, 1'b0, 1'b0, 1'b1, 128'hB22, 1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 2'b10, A_CH1, 7'd2};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 1'b1, 128'hC33, 1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 2'b00, 24'h0, 7'd1};
    vecs[7]  = '{2'b10, 1'b0, 1'b0, 1'b1, 128'hD44, 1'b1, 1'b0, A_CH1, 2'b10, 1'b0, 2'b01, A_CH0, 7'd1};
    vecs[8]  = '{2'b11, 1'b1, 1'b1, 1'b0, 128'h0,   1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 2'b00, 24'h0, 7'd1};
    vecs[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 128'h0,   1'b1, 1'b1, A_WR,  2'b00, 1'b1, 2'b00, 24'h0, 7'd2};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 1'b1, 128'hE55, 1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 2'b10, A_CH1, 7'd1};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 1'b1, 128'hF66, 1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 2'b00, 24'h0, 7'd0};

    for (int i = 0; i < 12; i++) begin
      rd_addr_axis_valid   = vecs[i].rd_v;
      wr_axis_valid        = vecs[i].wr_v;
      memrequest_busy      = vecs[i].busy;
      memrequest_complete  = vecs[i].cmpl;
      memrequest_resp_data = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_en", i), memrequest_en, vecs[i].en);
      chk($sformatf("v%0d_we", i), memrequest_write_enable, vecs[i].we);
      chk($sformatf("v%0d_addr", i), memrequest_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i), memrequest_write_data, vecs[i].we ? WDATA : '0);
      chk($sformatf("v%0d_rd_ready", i), rd_addr_axis_ready, vecs[i].rd_rdy);
      chk($sformatf("v%0d_wr_ready", i), wr_axis_ready, vecs[i].wr_rdy);
      chk($sformatf("v%0d_dvalid", i), rd_data_axis_valid, vecs[i].dv);
      if (vecs[i].dv != 2'b00) begin
        chk($sformatf("v%0d_ddata", i), rd_data_axis_data, vecs[i].rdata);
        chk($sformatf("v%0d_daddr", i), rd_data_axis_addr, vecs[i].daddr);
      end
      tick();
      chk($sformatf("v%0d_count", i), outstanding_count, vecs[i].cnt);
      $display("vector %0d: en=%0b we=%0b addr=%06h dv=%02b count=%0d", i,
               vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].dv, outstanding_count);
    end
    idle_inputs();

    // Credits: returns at full credit are ignored, so exactly 8 reads go out.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd_credit_return = 2'b01;
      tick();
    end
    rd_credit_return   = 2'b00;
    rd_addr_axis_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("credit_issue%0d", i), rd_addr_axis_ready[0], 1'b1);
      tick();
    end
    #1;
    chk("credit_withheld_ready", rd_addr_axis_ready[0], 1'b0);
    chk("credit_withheld_en", memrequest_en, 1'b0);
    chk("credit_count8", outstanding_count, 7'd8);
    $display("credit: 8 reads issued, 9th withheld");
    rd_credit_return = 2'b01;
    #1;
    chk("credit_return_same_cycle", rd_addr_axis_ready[0], 1'b0);
    tick();
    // Issue and return together leave the single credit in place.
    #1;
    chk("credit_after_return", rd_addr_axis_ready[0], 1'b1);
    tick();
    rd_credit_return = 2'b00;
    #1;
    chk("credit_issue_and_return", rd_addr_axis_ready[0], 1'b1);
    tick();
    #1;
    chk("credit_exhausted_again", rd_addr_axis_ready[0], 1'b0);
    chk("credit_count10", outstanding_count, 7'd10);

    // Reset mid-stream with requests in flight.
    wr_axis_valid = 1'b1;
    #1;
    chk("midrst_pre_en", memrequest_en, 1'b1);
    rst_dram_ctrl_n = 1'b0;
    #1;
    chk("midrst_en", memrequest_en, 1'b0);
    chk("midrst_wr_ready", wr_axis_ready, 1'b0);
    chk("midrst_count", outstanding_count, 7'd0);
    tick();
    wr_axis_valid   = 1'b0;
    rst_dram_ctrl_n = 1'b1;
    #1;
    chk("midrst_release_count", outstanding_count, 7'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("midrst_credit%0d", i), rd_addr_axis_ready[0], 1'b1);
      tick();
      #1;
    end
    chk("midrst_credit_withheld", rd_addr_axis_ready[0], 1'b0);
    $display("reset mid-stream: count and credits restored");

    // Fill the tag FIFO to its depth using writes.
    do_reset();
    rd_addr_axis_valid = 2'b00;
    wr_axis_valid      = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    chk("fill_count63", outstanding_count, 7'd63);
    memrequest_complete = 1'b1;
    #1;
    chk("fill_issue_and_complete_en", memrequest_en, 1'b1);
    tick();
    chk("fill_count_held63", outstanding_count, 7'd63);
    memrequest_complete = 1'b0;
    tick();
    chk("fill_count64", outstanding_count, 7'd64);
    chk("fill_full_en", memrequest_en, 1'b0);
    chk("fill_full_wr_ready", wr_axis_ready, 1'b0);
    memrequest_complete = 1'b1;
    #1;
    chk("fill_full_complete_en", memrequest_en, 1'b0);
    chk("fill_write_resp_silent", rd_data_axis_valid, 2'b00);
    tick();
    chk("fill_count_after_pop", outstanding_count, 7'd63);
    $display("fill: count reached 64, request held while full");
    idle_inputs();

    // Underflow: complete with nothing in flight.
    do_reset();
    memrequest_complete  = 1'b1;
    memrequest_resp_data = 128'h1234;
    #1;
    chk("uflow_no_valid", rd_data_axis_valid, 2'b00);
    chk("uflow_err_before_edge", err_underflow, 1'b0);
    tick();
    memrequest_complete = 1'b0;
    chk("uflow_err_set", err_underflow, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("uflow_err_sticky", err_underflow, 1'b1);
    chk("uflow_count", outstanding_count, 7'd0);
    $display("underflow: err_underflow=%0b", err_underflow);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
